// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath sharing one instruction/data memory.
// Outputs are decoded from the current state and the latched instruction fields.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_BIT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [2:0]            alu_ctrl,
  output logic [IMM_BIT-1:0]    imm_src,
  output logic                  illegal,
  output logic [3:0]            state_dbg
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_ILLEGAL  = 4'd12;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [IMM_BIT-1:0] IMM_I = IMM_BIT'(0);
  localparam logic [IMM_BIT-1:0] IMM_U = IMM_BIT'(1);
  localparam logic [IMM_BIT-1:0] IMM_S = IMM_BIT'(2);
  localparam logic [IMM_BIT-1:0] IMM_B = IMM_BIT'(3);
  localparam logic [IMM_BIT-1:0] IMM_J = IMM_BIT'(4);

  logic [3:0] state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       alu_f3_ok;
  logic       instr_unused;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_b5    = instr[30];
  assign alu_f3_ok    = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                        (funct3 == 3'b110) || (funct3 == 3'b111);
  assign instr_unused = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};
  assign state_dbg    = state_q;

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic is_r,
                                         input logic f7b5);
    case (f3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = alu_f3_ok ? S_EXEC_R : S_ILLEGAL;
          OP_I:         state_d = alu_f3_ok ? S_EXEC_I : S_ILLEGAL;
          OP_BR:        state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL:       state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_LUI: state_d = S_FETCH;
      default:    state_d = S_ILLEGAL;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctrl   = ALU_ADD;
    imm_src    = IMM_I;
    illegal    = 1'b0;
    // Reset gates every output so an aborted instruction cannot write anything.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_SW) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          mem_read = 1'b1;
          adr_src  = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_ctrl  = alu_dec(funct3, 1'b1, funct7_b5);
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_ctrl  = alu_dec(funct3, 1'b0, funct7_b5);
        end
        S_ALUWB:  reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = 2'b10;
          alu_ctrl  = ALU_SUB;
          pc_write  = funct3[0] ? ~zero : zero;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_LUI: begin
          imm_src    = IMM_U;
          result_src = 2'b11;
          reg_write  = 1'b1;
        end
        default:  illegal = 1'b1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected output vectors
// are queued when stimulus is driven and compared when the DUT is sampled.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero, mem_ready;
  logic        mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_ctrl, imm_src;
  logic        illegal;
  logic [3:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [22:0] exp_q[$];

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3, SLT = 3'd5;

  multicycle_ctrl #(.DATA_WIDTH(32), .IMM_BIT(3)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_ctrl(alu_ctrl), .imm_src(imm_src), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [22:0] out_vec;
  assign out_vec = {state_dbg, illegal, imm_src, alu_ctrl, result_src, alu_src_b,
                    alu_src_a, reg_write, pc_write, ir_write, adr_src, mem_write, mem_read};

  function automatic logic [22:0] ev(input logic [3:0] st, input logic rd, input logic wr,
                                     input logic adr, input logic irw, input logic pcw,
                                     input logic rgw, input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] rs, input logic [2:0] alu,
                                     input logic [2:0] imm, input logic ill);
    return {st, ill, imm, alu, rs, b, a, rgw, pcw, irw, adr, wr, rd};
  endfunction

  task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h (state got %0d exp %0d)", tag, got, exp,
               got[22:19], exp[22:19]);
    end
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic sample(input string tag, input logic [22:0] exp);
    logic [22:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    check(tag, out_vec, e);
  endtask

  // One clock cycle: drive at posedge+1, compare on the falling edge.
  task automatic cyc(input string tag, input logic mr, input logic z, input logic [22:0] exp);
    logic [22:0] e;
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, out_vec, e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] e_fetch(input logic mr);
    return ev(4'd0, 1, 0, 0, mr, mr, 0, 2'b00, 2'b10, 2'b10, ADD, 3'd0, 0);
  endfunction
  function automatic logic [22:0] e_decode(input logic [2:0] imm);
    return ev(4'd1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, ADD, imm, 0);
  endfunction
  function automatic logic [22:0] e_aluwb();
    return ev(4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, 3'd0, 0);
  endfunction

  task automatic fetch_decode(input logic [31:0] ins, input logic [2:0] imm);
    instr = ins;
    cyc("fetch", 1, 0, e_fetch(1));
    cyc("decode", 1, 0, e_decode(imm));
  endtask

  task automatic async_reset();
    mem_ready = 1'b1;
    rst = 1'b1;
    #1 sample("rst_async", '0);
    @(posedge clk);
    #1 sample("rst_hold", '0);
    rst = 1'b0;
  endtask

  task automatic alu_op(input string tag, input logic [31:0] ins, input logic is_r,
                        input logic [2:0] alu);
    fetch_decode(ins, 3'd3);
    if (is_r) cyc(tag, 1, 0, ev(4'd6, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, alu, 3'd0, 0));
    else      cyc(tag, 1, 0, ev(4'd7, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, alu, 3'd0, 0));
    cyc("aluwb", 1, 0, e_aluwb());
  endtask

  task automatic branch(input string tag, input logic [31:0] ins, input logic z,
                        input logic taken);
    fetch_decode(ins, 3'd3);
    cyc(tag, 1, z, ev(4'd9, 0, 0, 0, 0, taken, 0, 2'b10, 2'b00, 2'b00, SUB, 3'd0, 0));
  endtask

  initial begin
    rst = 1'b1; instr = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    cyc("reset_outputs", 1, 0, '0);
    rst = 1'b0;

    // Fetch stall, then addi x1,x0,5
    instr = 32'h00500093;
    cyc("fetch_stall", 0, 0, e_fetch(0));
    alu_op("exec_addi", 32'h00500093, 0, ADD);

    // lw with two wait states in MEMREAD
    fetch_decode(32'h0040A183, 3'd3);
    cyc("memadr_lw", 1, 0, ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ADD, 3'd0, 0));
    for (int i = 0; i < 3; i++)
      cyc("memread", (i == 2), 0, ev(4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'd0, 0));
    cyc("memwb", 1, 0, ev(4'd4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, ADD, 3'd0, 0));

    branch("beq_z1", 32'h00208463, 1, 1);
    branch("beq_z0", 32'h00208463, 0, 0);
    branch("bne_z1", 32'h00209463, 1, 0);
    branch("bne_z0", 32'h00209463, 0, 1);

    // jal: PC write, then rd <= OldPC+4 in ALUWB
    fetch_decode(32'h008000EF, 3'd4);
    cyc("jal", 1, 0, ev(4'd10, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, ADD, 3'd0, 0));
    cyc("jal_aluwb", 1, 0, e_aluwb());

    alu_op("exec_sub", 32'h402081B3, 1, SUB);
    alu_op("exec_slt", 32'h0020A1B3, 1, SLT);
    alu_op("exec_ori", 32'h00506093, 0, OR_);
    alu_op("exec_andi_b30", 32'h40007093, 0, AND_);
    alu_op("exec_addi_b30", 32'h40008093, 0, ADD);

    fetch_decode(32'h123450B7, 3'd3);
    cyc("lui", 1, 0, ev(4'd11, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, ADD, 3'd1, 0));

    // sw with one wait state
    fetch_decode(32'h0020A223, 3'd3);
    cyc("memadr_sw", 1, 0, ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ADD, 3'd2, 0));
    cyc("memwrite_wait", 0, 0, ev(4'd5, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'd0, 0));
    cyc("memwrite", 1, 0, ev(4'd5, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'd0, 0));

    // Undecodable opcode: absorbing ILLEGAL until reset
    fetch_decode(32'hFFFFFFFF, 3'd3);
    for (int i = 0; i < 10; i++)
      cyc("illegal_stuck", 1'($urandom_range(0, 1)), 0,
          ev(4'd12, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'd0, 1));
    async_reset();
    cyc("fetch_after_illegal", 1, 0, e_fetch(1));
    cyc("decode_after_illegal", 1, 0, e_decode(3'd3));
    cyc("illegal_again", 1, 0, ev(4'd12, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'd0, 1));
    async_reset();

    // Reset during a stalled store aborts it immediately
    fetch_decode(32'h0020A223, 3'd3);
    cyc("memadr_sw2", 1, 0, ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ADD, 3'd2, 0));
    mem_ready = 1'b0;
    #2 sample("memwrite_before_rst", ev(4'd5, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'd0, 0));
    async_reset();
    cyc("fetch_after_abort", 0, 0, e_fetch(0));

    // R-type with unsupported funct3 (sll)
    fetch_decode(32'h002091B3, 3'd3);
    cyc("illegal_sll", 1, 0, ev(4'd12, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'd0, 1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
